// File: rtl/approx_sub_pkg.sv
// Shared types and per-bit full-subtractor cell functions for serial_approx_sub.
package approx_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Approximate cell: no borrow propagation out of the low positions
  function automatic logic approx_fs_d(input logic x, input logic y, input logic bin);
    return (x | y) & ~bin;
  endfunction

  function automatic logic exact_fs_d(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  function automatic logic exact_fs_b(input logic x, input logic y, input logic bin);
    return (~x & y) | (~x & bin) | (y & bin);
  endfunction

endpackage

// File: rtl/serial_approx_sub_fs_cell.sv
// Combinational one-bit full-subtractor cell, exact or approximate per approx_i.
module fs_cell
  import approx_sub_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  input  logic approx_i,
  output logic d_o,
  output logic bout_o
);

  always_comb begin
    if (approx_i) begin
      d_o    = approx_fs_d(x_i, y_i, bin_i);
      bout_o = 1'b0;
    end else begin
      d_o    = exact_fs_d(x_i, y_i, bin_i);
      bout_o = exact_fs_b(x_i, y_i, bin_i);
    end
  end

endmodule

// File: rtl/serial_approx_sub.sv
// Bit-serial approximate subtractor, LSB first, one bit per clock.
// Define APPROX_SUB_ERR_EN to add a shadow exact chain and the err_dist output.
module serial_approx_sub
  import approx_sub_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
`ifdef APPROX_SUB_ERR_EN
  ,
  output logic [WIDTH:0]   err_dist
`endif
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Bit i set selects the approximate cell at position i
  localparam logic [WIDTH:0] APPROX_MASK =
    ({{WIDTH{1'b0}}, 1'b1} << APPROX_BITS) - {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             cell_diff, cell_bout;
  logic             approx_sel;
  logic             last_bit;

  assign approx_sel = APPROX_MASK[idx_q];
  assign last_bit   = (idx_q == IDXW'(WIDTH - 1));
  assign diff       = diff_q;

  fs_cell u_cell (
    .x_i      (a_q[idx_q]),
    .y_i      (b_q[idx_q]),
    .bin_i    (borrow_q),
    .approx_i (approx_sel),
    .d_o      (cell_diff),
    .bout_o   (cell_bout)
  );

`ifdef APPROX_SUB_ERR_EN
  logic [WIDTH:0] exact_q, exact_d;
  logic [WIDTH:0] err_q, err_d;
  logic           shb_q, shb_d;
  logic           shd_diff, shd_bout;

  assign err_dist = err_q;

  fs_cell u_shadow (
    .x_i      (a_q[idx_q]),
    .y_i      (b_q[idx_q]),
    .bin_i    (shb_q),
    .approx_i (1'b0),
    .d_o      (shd_diff),
    .bout_o   (shd_bout)
  );
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef APPROX_SUB_ERR_EN
    exact_d   = exact_q;
    shb_d     = shb_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = in1;
          b_d      = in2;
          idx_d    = '0;
          borrow_d = 1'b0;
`ifdef APPROX_SUB_ERR_EN
          shb_d    = 1'b0;
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[idx_q] = cell_diff;
        borrow_d      = cell_bout;
        idx_d         = idx_q + 1'b1;
`ifdef APPROX_SUB_ERR_EN
        exact_d[idx_q] = shd_diff;
        shb_d          = shd_bout;
`endif
        if (last_bit) begin
          diff_d[WIDTH] = cell_bout;
          idx_d         = '0;
          state_d       = DONE;
`ifdef APPROX_SUB_ERR_EN
          // Distance is formed from the completed next-state words so it is valid with out_valid
          exact_d[WIDTH] = shd_bout;
          err_d = (exact_d > diff_d) ? (exact_d - diff_d) : (diff_d - exact_d);
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
`ifdef APPROX_SUB_ERR_EN
      exact_q  <= '0;
      shb_q    <= 1'b0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
`ifdef APPROX_SUB_ERR_EN
      exact_q  <= exact_d;
      shb_q    <= shb_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_approx_sub.sv
// Randomized self-checking bench for serial_approx_sub; three instances with APPROX_BITS 3, 0 and 8.
module tb_serial_approx_sub;

  localparam int unsigned W  = 8;
  localparam int          NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_s     [NI];
  logic         in_valid_s  [NI];
  logic         in_ready_s  [NI];
  logic         out_valid_s [NI];
  logic         out_ready_s [NI];
  logic [W-1:0] in1_s       [NI];
  logic [W-1:0] in2_s       [NI];
  logic [W:0]   diff_s      [NI];
`ifdef APPROX_SUB_ERR_EN
  logic [W:0]   err_s       [NI];
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_approx_sub #(
      .WIDTH       (W),
      .APPROX_BITS ((g == 0) ? 3 : ((g == 1) ? 0 : 8))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .in1       (in1_s[g]),
      .in2       (in2_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .diff      (diff_s[g])
`ifdef APPROX_SUB_ERR_EN
      ,
      .err_dist  (err_s[g])
`endif
    );
  end

  function automatic int unsigned ab_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 0 : 8);
  endfunction

  // Low ab bits are a|b with no borrow out; upper bits are an ordinary subtraction
  function automatic logic [W:0] ref_approx(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int unsigned ab);
    int lowm, up, t;
    lowm = (1 << ab) - 1;
    up   = int'(a >> ab) - int'(b >> ab);
    t    = (up << ab) | (int'(a | b) & lowm);
    return t[W:0];
  endfunction

  function automatic logic [W:0] ref_exact(input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    t = int'(a) - int'(b);
    return t[W:0];
  endfunction

  function automatic logic [W:0] ref_err(input logic [W:0] ex, input logic [W:0] ap);
    int e;
    e = int'(ex) - int'(ap);
    if (e < 0) e = -e;
    return e[W:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int idle, input int hold);
    logic [W:0] exp_d;
    int c;
    exp_d = ref_approx(a, b, ab_of(k));
    repeat (idle) @(negedge clk);
    in_valid_s[k] = 1'b1;
    in1_s[k]      = a;
    in2_s[k]      = b;
    c = 0;
    while (!in_ready_s[k] && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("accept_wait", (c < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Operand changes while running must not matter
    in_valid_s[k] = 1'b0;
    in1_s[k]      = W'($urandom_range(0, 255));
    in2_s[k]      = W'($urandom_range(0, 255));
    c = 0;
    while (!out_valid_s[k] && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("latency", c, W);
    chk("diff", diff_s[k], exp_d);
    chk("ready_in_done", in_ready_s[k], 1'b0);
`ifdef APPROX_SUB_ERR_EN
    chk("err_dist", err_s[k], ref_err(ref_exact(a, b), exp_d));
`endif
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid_s[k], 1'b1);
      chk("hold_diff", diff_s[k], exp_d);
      chk("hold_ready", in_ready_s[k], 1'b0);
    end
    out_ready_s[k] = 1'b1;
    @(negedge clk);
    out_ready_s[k] = 1'b0;
    chk("release_valid", out_valid_s[k], 1'b0);
    chk("release_ready", in_ready_s[k], 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    for (int k = 0; k < NI; k++) begin
      rst_n_s[k]     = 1'b0;
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      in1_s[k]       = '0;
      in2_s[k]       = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", in_ready_s[k], 1'b1);
      chk("rst_out_valid", out_valid_s[k], 1'b0);
      chk("rst_diff", diff_s[k], '0);
`ifdef APPROX_SUB_ERR_EN
      chk("rst_err", err_s[k], '0);
`endif
      rst_n_s[k] = 1'b1;
    end

    run_txn(0, 8'h10, 8'h01, 0, 0);
    run_txn(0, 8'h05, 8'h0A, 1, 5);
    run_txn(1, 8'h05, 8'h0A, 0, 0);
    run_txn(2, 8'hA0, 8'h0C, 0, 0);

    // Reset while bit index 4 is being processed
    @(negedge clk);
    in_valid_s[0] = 1'b1;
    in1_s[0]      = 8'h33;
    in2_s[0]      = 8'h11;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    rst_n_s[0]    = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid_s[0], 1'b0);
    chk("midrst_diff", diff_s[0], '0);
    chk("midrst_ready", in_ready_s[0], 1'b1);
`ifdef APPROX_SUB_ERR_EN
    chk("midrst_err", err_s[0], '0);
`endif
    rst_n_s[0] = 1'b1;
    c = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_s[0]) c++;
    end
    chk("no_out_after_rst", c, 0);
    run_txn(0, 8'hFF, 8'h00, 0, 0);

    for (int n = 0; n < 1000; n++) begin
      run_txn(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
    for (int n = 0; n < 100; n++) begin
      run_txn(1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              $urandom_range(0, 2), $urandom_range(0, 2));
      run_txn(2, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
              $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
